// File: rtl/quantum_scheduler_pkg.sv
// Shared definitions for the quantum scheduler: FSM encoding, default user-space base
// and the saturating increment used by the retire counters.
package quantum_scheduler_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_RUN    = 2'd2,
    S_SAVE   = 2'd3
  } state_e;

  // Preemption vectors the pipeline to this address.
  localparam logic [31:0] OS_ENTRY        = 32'd0;
  localparam int          OS_BASE_DEFAULT = 687;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/quantum_scheduler_rr_picker.sv
// Combinational round-robin search: first set bit of valid_i at or after start_i,
// wrapping modulo NPROC.
module quantum_scheduler_rr_picker #(
  parameter int NPROC = 8
) (
  input  logic [NPROC-1:0]         valid_i,
  input  logic [$clog2(NPROC)-1:0] start_i,
  output logic                     found_o,
  output logic [$clog2(NPROC)-1:0] idx_o
);
  localparam int IDW = $clog2(NPROC);

  logic [IDW-1:0] cand;

  // Walk from the farthest candidate down so the nearest hit is written last.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int i = NPROC - 1; i >= 0; i--) begin
      cand = start_i + IDW'(i);
      if (valid_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/quantum_scheduler.sv
// Round-robin process scheduler with retire-count quantum preemption.
// Optional per-slot retire statistics are enabled by defining SCHED_STATS_EN.
module quantum_scheduler
  import quantum_scheduler_pkg::*;
#(
  parameter int NPROC   = 8,
  parameter int PCW     = 32,
  parameter int OS_BASE = OS_BASE_DEFAULT
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     instr_retire,
  input  logic [PCW-1:0]           pc_cur,
  input  logic [PCW-1:0]           pc_next,
  input  logic                     q_load,
  input  logic [31:0]              q_value,
  input  logic                     proc_create,
  input  logic [$clog2(NPROC)-1:0] create_id,
  input  logic [PCW-1:0]           create_pc,
  input  logic                     proc_halt,
  input  logic                     sched_req,
  output logic                     dispatch,
  output logic [$clog2(NPROC)-1:0] next_id,
  output logic [PCW-1:0]           next_pc,
  output logic                     no_proc,
  output logic                     preempt,
  output logic                     running,
  output logic [$clog2(NPROC)-1:0] cur_id
`ifdef SCHED_STATS_EN
  ,
  input  logic [$clog2(NPROC)-1:0] stat_id,
  output logic [31:0]              stat_count
`endif
);
  localparam int             IDW        = $clog2(NPROC);
  localparam logic [PCW-1:0] OS_BASE_PC = PCW'(OS_BASE);

  state_e           state_q, state_d;
  logic [NPROC-1:0] valid_q, valid_d;
  logic [PCW-1:0]   saved_pc_q [NPROC];
  logic [PCW-1:0]   saved_pc_d [NPROC];
  logic [IDW-1:0]   cur_id_q, cur_id_d;
  logic [31:0]      qcnt_q, qcnt_d;
  logic [31:0]      qlim_q, qlim_d;
  logic             dispatch_q, dispatch_d;
  logic             no_proc_q, no_proc_d;
  logic             preempt_q, preempt_d;
  logic [IDW-1:0]   next_id_q, next_id_d;
  logic [PCW-1:0]   next_pc_q, next_pc_d;

  logic             counted;
  logic             expire;
  logic [32:0]      qinc;
  logic             pick_found;
  logic [IDW-1:0]   pick_idx;

  quantum_scheduler_rr_picker #(.NPROC(NPROC)) u_picker (
    .valid_i (valid_q),
    .start_i (cur_id_q + IDW'(1)),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    saved_pc_d = saved_pc_q;
    cur_id_d   = cur_id_q;
    qcnt_d     = qcnt_q;
    qlim_d     = qlim_q;
    dispatch_d = 1'b0;
    no_proc_d  = 1'b0;
    preempt_d  = 1'b0;
    next_id_d  = next_id_q;
    next_pc_d  = next_pc_q;
    counted    = (state_q == S_RUN) && instr_retire && (pc_cur >= OS_BASE_PC);
    qinc       = {1'b0, qcnt_q} + 33'd1;
    expire     = counted && (qlim_q != 32'd0) && (qinc == {1'b0, qlim_q});

    case (state_q)
      S_IDLE: begin
        if (sched_req) state_d = S_SELECT;
      end
      S_SELECT: begin
        if (pick_found) begin
          dispatch_d = 1'b1;
          next_id_d  = pick_idx;
          next_pc_d  = saved_pc_q[pick_idx];
          cur_id_d   = pick_idx;
          qcnt_d     = '0;
          state_d    = S_RUN;
        end else begin
          no_proc_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_RUN: begin
        if (counted) qcnt_d = sat_inc(qcnt_q);
        // A halting process never gets preempted, even on its expiring retire.
        if (proc_halt) begin
          valid_d[cur_id_q] = 1'b0;
          state_d           = S_IDLE;
        end else if (expire) begin
          saved_pc_d[cur_id_q] = pc_next;
          preempt_d            = 1'b1;
          state_d              = S_SAVE;
        end
      end
      S_SAVE: begin
        qcnt_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (q_load) qlim_d = q_value;
    // Applied last so a create on the halting slot leaves it valid.
    if (proc_create) begin
      valid_d[create_id]    = 1'b1;
      saved_pc_d[create_id] = create_pc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      valid_q    <= '0;
      for (int i = 0; i < NPROC; i++) saved_pc_q[i] <= '0;
      cur_id_q   <= IDW'(NPROC - 1);
      qcnt_q     <= '0;
      qlim_q     <= '0;
      dispatch_q <= 1'b0;
      no_proc_q  <= 1'b0;
      preempt_q  <= 1'b0;
      next_id_q  <= '0;
      next_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      saved_pc_q <= saved_pc_d;
      cur_id_q   <= cur_id_d;
      qcnt_q     <= qcnt_d;
      qlim_q     <= qlim_d;
      dispatch_q <= dispatch_d;
      no_proc_q  <= no_proc_d;
      preempt_q  <= preempt_d;
      next_id_q  <= next_id_d;
      next_pc_q  <= next_pc_d;
    end
  end

  // Pulses are masked while reset is high so a reset landing in SAVE emits nothing.
  assign dispatch = dispatch_q & ~reset;
  assign no_proc  = no_proc_q & ~reset;
  assign preempt  = preempt_q & ~reset;
  assign running  = (state_q == S_RUN) & ~reset;
  assign cur_id   = running ? cur_id_q : '0;
  assign next_id  = next_id_q;
  assign next_pc  = next_pc_q;

`ifdef SCHED_STATS_EN
  logic [31:0] stat_q [NPROC];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NPROC; i++) stat_q[i] <= '0;
    end else begin
      if (counted) stat_q[cur_id_q] <= sat_inc(stat_q[cur_id_q]);
      if (proc_create) stat_q[create_id] <= '0;
    end
  end

  assign stat_count = stat_q[stat_id];
`endif

endmodule

// File: tb/tb_quantum_scheduler.sv
// Scoreboard bench for quantum_scheduler: stimulus queues expected pulses,
// a negedge monitor pops and compares them.
module tb_quantum_scheduler;

  localparam int NPROC = 8;
  localparam int PCW   = 32;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             instr_retire = 1'b0;
  logic [PCW-1:0]   pc_cur = '0;
  logic [PCW-1:0]   pc_next = '0;
  logic             q_load = 1'b0;
  logic [31:0]      q_value = '0;
  logic             proc_create = 1'b0;
  logic [2:0]       create_id = '0;
  logic [PCW-1:0]   create_pc = '0;
  logic             proc_halt = 1'b0;
  logic             sched_req = 1'b0;
  logic             dispatch;
  logic [2:0]       next_id;
  logic [PCW-1:0]   next_pc;
  logic             no_proc;
  logic             preempt;
  logic             running;
  logic [2:0]       cur_id;

  quantum_scheduler #(.NPROC(NPROC), .PCW(PCW), .OS_BASE(687)) dut (
    .clock        (clock),
    .reset        (reset),
    .instr_retire (instr_retire),
    .pc_cur       (pc_cur),
    .pc_next      (pc_next),
    .q_load       (q_load),
    .q_value      (q_value),
    .proc_create  (proc_create),
    .create_id    (create_id),
    .create_pc    (create_pc),
    .proc_halt    (proc_halt),
    .sched_req    (sched_req),
    .dispatch     (dispatch),
    .next_id      (next_id),
    .next_pc      (next_pc),
    .no_proc      (no_proc),
    .preempt      (preempt),
    .running      (running),
    .cur_id       (cur_id)
  );

  always #5 clock = ~clock;

  // kind: 0 dispatch, 1 no_proc, 2 preempt
  typedef struct {
    int kind;
    int id;
    int pc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   compared   = 0;
  int   mismatched = 0;
  int   got_kind;

  always @(negedge clock) begin
    if (dispatch || no_proc || preempt) begin
      compared++;
      got_kind = dispatch ? 0 : (no_proc ? 1 : 2);
      if ((int'(dispatch) + int'(no_proc) + int'(preempt)) > 1) begin
        mismatched++;
        $display("FAIL pulse_overlap actual d=%0b n=%0b p=%0b required one-hot",
                 dispatch, no_proc, preempt);
      end else if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_pulse actual kind=%0d id=%0d pc=%0d required none",
                 got_kind, next_id, next_pc);
      end else begin
        mon_e = exp_q.pop_front();
        if (got_kind != mon_e.kind ||
            (mon_e.kind == 0 && (int'(next_id) != mon_e.id || int'(next_pc) != mon_e.pc))) begin
          mismatched++;
          $display("FAIL pulse actual kind=%0d id=%0d pc=%0d required kind=%0d id=%0d pc=%0d",
                   got_kind, next_id, next_pc, mon_e.kind, mon_e.id, mon_e.pc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_ev(input int kind, input int id, input int pc);
    exp_t e;
    e.kind = kind;
    e.id   = id;
    e.pc   = pc;
    exp_q.push_back(e);
  endtask

  task automatic create(input int id, input int pc);
    proc_create = 1'b1;
    create_id   = 3'(id);
    create_pc   = PCW'(pc);
    tick();
    proc_create = 1'b0;
  endtask

  // Raise the request for one IDLE cycle, then wait past the registered pulse.
  task automatic request();
    sched_req = 1'b1;
    tick();
    sched_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic retire(input int n, input int pcc, input int pcn);
    instr_retire = 1'b1;
    pc_cur       = PCW'(pcc);
    pc_next      = PCW'(pcn);
    repeat (n) tick();
    instr_retire = 1'b0;
  endtask

  task automatic halt();
    proc_halt = 1'b1;
    tick();
    proc_halt = 1'b0;
  endtask

  task automatic drained(input string name);
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_outputs", {dispatch, no_proc, preempt, running, cur_id, next_id, next_pc},
        64'd0);
    reset = 1'b0;
    tick();
    chk("idle_running", 64'(running), 64'd0);

    // Basic dispatch and round robin after halt
    create(0, 700);
    create(2, 900);
    expect_ev(0, 0, 700);
    request();
    chk("run1_running", 64'(running), 64'd1);
    chk("run1_cur_id", 64'(cur_id), 64'd0);
    halt();
    chk("halt1_running", 64'(running), 64'd0);
    expect_ev(0, 2, 900);
    request();
    chk("run2_cur_id", 64'(cur_id), 64'd2);
    halt();
    drained("basic_drained");

    // Quantum expiry saves pc_next and later resumes there
    create(0, 700);
    q_load  = 1'b1;
    q_value = 32'd3;
    tick();
    q_load = 1'b0;
    expect_ev(0, 0, 700);
    request();
    retire(2, 700, 703);
    chk("q_pre_running", 64'(running), 64'd1);
    expect_ev(2, 0, 0);
    retire(1, 702, 703);
    chk("q_save_running", 64'(running), 64'd0);
    tick();
    expect_ev(0, 0, 703);
    request();
    drained("quantum_drained");

    // OS-space retires (just below the boundary) are not counted
    retire(2, 710, 711);
    retire(4, 686, 800);
    chk("os_retire_running", 64'(running), 64'd1);
    expect_ev(2, 0, 0);
    retire(1, 687, 750);
    tick();
    expect_ev(0, 0, 750);
    request();
    drained("os_drained");

    // Halt wins over an expiring retire in the same cycle
    retire(2, 750, 751);
    instr_retire = 1'b1;
    pc_cur       = 32'd752;
    pc_next      = 32'd753;
    proc_halt    = 1'b1;
    tick();
    instr_retire = 1'b0;
    proc_halt    = 1'b0;
    chk("halt_exp_running", 64'(running), 64'd0);
    tick();
    tick();

    // Empty table yields no_proc
    expect_ev(1, 0, 0);
    request();
    chk("noproc_running", 64'(running), 64'd0);
    drained("noproc_drained");

    // Round robin wrap, create beating halt on the running slot
    create(5, 1500);
    create(1, 1100);
    expect_ev(0, 1, 1100);
    request();
    proc_halt   = 1'b1;
    proc_create = 1'b1;
    create_id   = 3'd1;
    create_pc   = 32'd1200;
    tick();
    proc_halt   = 1'b0;
    proc_create = 1'b0;
    expect_ev(0, 5, 1500);
    request();
    chk("rr5_cur_id", 64'(cur_id), 64'd5);
    halt();
    expect_ev(0, 1, 1200);
    request();
    chk("rr_wrap_cur_id", 64'(cur_id), 64'd1);
    drained("rr_drained");

    // Reset arriving in SAVE suppresses the preempt and clears the table
    retire(3, 1200, 1203);
    reset = 1'b1;
    #2;
    chk("rst_save_outputs", {dispatch, no_proc, preempt, running, cur_id}, 64'd0);
    tick();
    chk("rst_after_outputs", {dispatch, no_proc, preempt, running, cur_id}, 64'd0);
    reset = 1'b0;
    tick();
    expect_ev(1, 0, 0);
    request();
    tick();
    drained("final_drained");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/quantum_scheduler.md
# quantum_scheduler

Round-robin process scheduler that shares the single processor pipeline between up to NPROC user processes and the OS. It keeps a small process table with each process's valid bit and saved PC. It counts retired user instructions against a programmable quantum, and preempts the running process when the quantum expires. When the OS requests a dispatch, it selects the next ready process and supplies that process's resume PC to the PC register.

## Interface
Parameters:
- NPROC, 8, number of process slots (power of two, 2..16)
- PCW, 32, PC width
- OS_BASE, 687, first user-space address; PCs below it are OS code

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high
- instr_retire  in  1  one instruction retired this cycle
- pc_cur  in  PCW  PC of the retiring instruction
- pc_next  in  PCW  PC the pipeline would fetch next
- q_load  in  1  load quantum limit
- q_value  in  32  quantum limit; 0 disables preemption
- proc_create  in  1  install a process
- create_id  in  $clog2(NPROC)  slot to install
- create_pc  in  PCW  start PC for that slot
- proc_halt  in  1  the running process executed halt
- sched_req  in  1  OS requests dispatch (level; sampled in IDLE only)
- dispatch  out  1  one-cycle pulse: jump to next_pc
- next_id  out  $clog2(NPROC)  selected slot
- next_pc  out  PCW  resume PC of the selected slot
- no_proc  out  1  one-cycle pulse: dispatch requested, no slot valid
- preempt  out  1  one-cycle pulse: force PC to 0 (OS entry)
- running  out  1  a user process owns the CPU
- cur_id  out  $clog2(NPROC)  owner slot, valid while running

## Operation
- Process table: valid[NPROC], saved_pc[NPROC]. Current slot is cur_id, quantum counter is qcnt (32 b), limit register is qlim.
- FSM states: IDLE, SELECT, RUN, SAVE.
- IDLE: OS is executing. When sched_req=1, go to SELECT.
- SELECT: round-robin search over valid[], starting at slot cur_id+1 (mod NPROC) and wrapping.
  - If a slot is found: dispatch=1, next_id/next_pc driven from the table, cur_id updated, qcnt←0, go to RUN.
  - Otherwise: no_proc=1, return to IDLE.
- RUN: on instr_retire with pc_cur ≥ OS_BASE, qcnt←qcnt+1. Retires with pc_cur < OS_BASE do not count.
  - If qlim≠0 and a counted retire makes qcnt+1 == qlim: saved_pc[cur_id]←pc_next, go to SAVE.
  - If proc_halt=1: valid[cur_id]←0, go to IDLE without asserting preempt.
  - proc_halt takes priority over quantum expiry in the same cycle.
- SAVE: preempt=1 for one cycle, qcnt←0, go to IDLE. The slot stays valid.
- q_load: qlim←q_value in any state. A new qlim takes effect on the next counted retire; the counter is not cleared.
- proc_create: valid[create_id]←1, saved_pc[create_id]←create_pc, accepted in any state.
  - If it targets the running slot during RUN, only the table is updated; execution continues.
  - create on the same slot and cycle as halt: create wins (valid ends at 1).
- Arithmetic: qcnt saturates at 2^32−1. Slot index wraps mod NPROC.

## Timing
- Reset values: state=IDLE, valid=0, saved_pc=0, qcnt=0, qlim=0, cur_id=NPROC−1 (so the first search starts at slot 0). All outputs are 0.
- sched_req sampled in IDLE → dispatch or no_proc two cycles later (IDLE→SELECT→output registered on SELECT exit).
- Expiring retire at cycle t → SAVE at t+1 → preempt high during t+1 → IDLE at t+2.
- dispatch, no_proc and preempt are registered single-cycle pulses and are never asserted together.
- reset mid-RUN or mid-SAVE: the next cycle is IDLE, no pulse is emitted, and the table is cleared.

## Configuration
- SCHED_STATS_EN defined: adds a per-slot 32-bit counter of counted retires, plus ports stat_id (in) and stat_count (out, combinational read).
  - Counters clear on reset and when the slot receives proc_create.
- SCHED_STATS_EN undefined: no counters and no stat ports.

## Structure
- Shared header sched_defs.vh holds:
  - FSM state encodings (S_IDLE, S_SELECT, S_RUN, S_SAVE)
  - OS entry address (0)
  - default OS_BASE
- Sub-module rr_picker: combinational round-robin priority search.
  - Inputs: valid mask and start index.
  - Outputs: found and index.

## Test plan
- Create slots 0 (pc 700) and 2 (pc 900), pulse sched_req → dispatch with next_id=0, next_pc=700; second request after halt → next_id=2, next_pc=900.
- qlim=3, three user retires with pc_next 703 → preempt pulse on the cycle after the third; saved_pc[0]=703; next dispatch of slot 0 returns 703.
- qlim=3, retires with pc_cur=100 (OS) during RUN → qcnt unchanged, no preempt.
- Expiring retire and proc_halt in the same cycle → no preempt, valid[cur]=0, state IDLE.
- No valid slots and sched_req → no_proc pulse two cycles later, dispatch stays 0.
- Reset asserted in SAVE → preempt not asserted, all outputs 0, and the next request with an empty table yields no_proc.
